spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Shares one SPI_mstr16 between two requesters: port 0 is the inertial interface (4-transaction read bursts), port 1 is the A2D/battery interface.
- Arbitration is round-robin with a burst lock and an idle-grant watchdog.
- Routes cmd/wrt to the master and done back to the owner, and steers the master's SS_n to the owner's chip-select line.
- Sits between the requesters and SPI_mstr16, inside the top-level Segway digital core.

Parameters:
- TMO_CYC, 1024, cycles a grant may stay idle (no wrt) before the grant is revoked.
- TMO_W, 11, timeout counter width; must satisfy 2^TMO_W > TMO_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  requester wants the bus; held until done with it
- lock0 / lock1  in  1  keep ownership after the current transfer (burst)
- wrt0 / wrt1  in  1  start transfer; honoured only while granted and in GNT
- cmd0 / cmd1  in  16  SPI command word of each requester
- gnt0 / gnt1  out  1  registered grant
- done0 / done1  out  1  one-cycle transfer-complete pulse to owner
- m_wrt  out  1  to SPI_mstr16 wrt
- m_cmd  out  16  to SPI_mstr16 cmd
- m_done  in  1  from SPI_mstr16 done
- m_SS_n  in  1  from SPI_mstr16 SS_n
- SS0_n / SS1_n  out  1  per-device chip selects

Behaviour:
- Reset: state=IDLE, gnt0=gnt1=0, done0=done1=0, m_wrt=0, m_cmd=16'h0000, SS0_n=SS1_n=1, last=1 (port 0 wins the first tie), tmo=0.
- The rd_data path is not routed; requesters tap SPI_mstr16 rd_data directly and qualify it with their own done.
- State machine {IDLE, GNT, BUSY} plus an owner bit:
  - IDLE, only req0 -> owner=0, gnt0=1 next cycle, go GNT. Only req1 -> symmetric.
  - IDLE, req0 and req1 together -> owner = ~last.
  - GNT, wrt_owner=1 -> m_wrt=1 and m_cmd=cmd_owner in the same cycle (combinational pass-through), go BUSY, tmo cleared.
  - GNT, req_owner=0 -> release: gnt cleared next cycle, last=owner, go IDLE.
  - GNT, tmo reaches TMO_CYC-1 without wrt -> same release as above. The counter increments only in GNT.
  - BUSY: m_wrt=0, m_cmd held at the owner's cmd, wrt inputs ignored.
  - BUSY, m_done=1 -> done_owner=1 (combinational, same cycle). Then lock_owner=1 -> GNT (same owner, tmo=0); else release to IDLE with last=owner.
- Single-owner guarantee: gnt0 and gnt1 are never both 1. A wrt from the non-owner is dropped with no side effect.
- m_cmd = cmd of the current owner in GNT/BUSY, 16'h0000 in IDLE.
- SS steering: SSx_n = m_SS_n when owner==x and state≠IDLE, else 1.
- req_owner dropping in BUSY does not abort the transfer; release happens at m_done.
- rst asserted mid-transfer: next cycle IDLE, grants low, SS0_n=SS1_n=1. SPI_mstr16 is reset by the same system reset, so no orphan done reaches a requester.
- A requester may hold req with lock low; after each transfer it re-arbitrates and alternates with the other port.

Decomposition:
- Shared package spi_arb_pkg:
  - typedef enum {IDLE, GNT, BUSY} arb_state_t
  - owner encoding localparams OWN_INERT=0, OWN_A2D=1
  - default TMO_CYC
- No sub-module is required. The timeout counter is the one natural candidate for extraction (arb_tmo_cnt); otherwise keep it inline.

Test Plan:
- req0 only, cmd0=16'hA2XX, wrt0 pulse → gnt0=1 one cycle after req0; m_cmd=A2XX with m_wrt pulse; on m_done, done0 pulses and SS1_n stays 1 throughout.
- req0 and req1 both asserted out of reset, lock low → gnt0 first; after its m_done, gnt1; after that, gnt0 again (strict alternation).
- Inertial burst: lock0=1 for 4 transfers with req1 pending → gnt1 stays 0 until lock0 drops; req1 is granted on the cycle after the 4th m_done.
- gnt1 held with no wrt1 → release after exactly TMO_CYC cycles in GNT, gnt1→0, pending req0 granted.
- wrt1 asserted while owner=0 in GNT → no m_wrt, m_cmd unchanged, no done1; rst asserted mid-BUSY → next cycle IDLE, gnt0=gnt1=0, SS0_n=SS1_n=1.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    BUSY = 2'd2
  } arb_state_t;

  // Owner encoding: port 0 is the inertial sensor, port 1 is the A2D.
  localparam logic OWN_INERT = 1'b0;
  localparam logic OWN_A2D   = 1'b1;

  localparam int TMO_CYC_DEFAULT = 1024;
  localparam int CMD_W           = 16;

endpackage

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI_mstr16 between the inertial interface
// (port 0) and the A2D interface (port 1). Supports burst locking and revokes
// a grant that sits idle for TMO_CYC cycles. Data read back from the master is
// not routed here; requesters qualify it with their own done pulse.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEFAULT,
  parameter int TMO_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             wrt0,
  input  logic             wrt1,
  input  logic [CMD_W-1:0] cmd0,
  input  logic [CMD_W-1:0] cmd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             m_wrt,
  output logic [CMD_W-1:0] m_cmd,
  input  logic             m_done,
  input  logic             m_SS_n,
  output logic             SS0_n,
  output logic             SS1_n
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q,  last_d;
  logic [TMO_W-1:0] tmo_q,   tmo_d;
  logic             gnt0_q,  gnt0_d;
  logic             gnt1_q,  gnt1_d;

  logic             req_own;
  logic             wrt_own;
  logic             lock_own;
  logic [CMD_W-1:0] cmd_own;

  // Select the current owner's request-side signals.
  always_comb begin
    req_own  = (owner_q == OWN_A2D) ? req1  : req0;
    wrt_own  = (owner_q == OWN_A2D) ? wrt1  : wrt0;
    lock_own = (owner_q == OWN_A2D) ? lock1 : lock0;
    cmd_own  = (owner_q == OWN_A2D) ? cmd1  : cmd0;
  end

  // Next-state logic: arbitration, burst lock, idle-grant timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (req0 && req1) begin
          // Tie: the port that did not own the bus last time wins.
          owner_d = ~last_q;
          state_d = GNT;
        end else if (req0) begin
          owner_d = OWN_INERT;
          state_d = GNT;
        end else if (req1) begin
          owner_d = OWN_A2D;
          state_d = GNT;
        end
      end
      GNT: begin
        if (wrt_own) begin
          state_d = BUSY;
          tmo_d   = '0;
        end else if (!req_own || (tmo_q == TMO_LAST)) begin
          state_d = IDLE;
          last_d  = owner_q;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      BUSY: begin
        // A dropped request does not abort an in-flight transfer.
        if (m_done) begin
          tmo_d = '0;
          if (lock_own) begin
            state_d = GNT;
          end else begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
    endcase
    gnt0_d = (state_d != IDLE) && (owner_d == OWN_INERT);
    gnt1_d = (state_d != IDLE) && (owner_d == OWN_A2D);
  end

  // Arbiter state registers; last starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_INERT;
      last_q  <= 1'b1;
      tmo_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // Master-side routing, done steering and chip-select steering.
  always_comb begin
    gnt0  = gnt0_q;
    gnt1  = gnt1_q;
    m_wrt = (state_q == GNT) && wrt_own;
    m_cmd = (state_q == IDLE) ? '0 : cmd_own;
    done0 = (state_q == BUSY) && m_done && (owner_q == OWN_INERT);
    done1 = (state_q == BUSY) && m_done && (owner_q == OWN_A2D);
    SS0_n = ((state_q != IDLE) && (owner_q == OWN_INERT)) ? m_SS_n : 1'b1;
    SS1_n = ((state_q != IDLE) && (owner_q == OWN_A2D))   ? m_SS_n : 1'b1;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus pushes expected master writes and
// done pulses, a negedge monitor pops and compares them.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int XFER = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, wrt0, wrt1;
  logic [15:0] cmd0, cmd1;
  logic        gnt0, gnt1, done0, done1, m_wrt;
  logic [15:0] m_cmd;
  logic        m_done, m_SS_n;
  logic        SS0_n, SS1_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_done;
    bit          port;
    logic [15:0] cmd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .lock0 (lock0),
    .lock1 (lock1),
    .wrt0  (wrt0),
    .wrt1  (wrt1),
    .cmd0  (cmd0),
    .cmd1  (cmd1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .m_wrt (m_wrt),
    .m_cmd (m_cmd),
    .m_done(m_done),
    .m_SS_n(m_SS_n),
    .SS0_n (SS0_n),
    .SS1_n (SS1_n)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple SPI_mstr16 stand-in: SS_n low for the transfer, done after XFER cycles.
  initial begin
    m_done = 1'b0;
    m_SS_n = 1'b1;
    forever begin
      @(negedge clk);
      if (m_wrt) begin
        @(posedge clk);
        #1 m_SS_n = 1'b0;
        repeat (XFER) @(posedge clk);
        #1 m_done = 1'b1;
        @(posedge clk);
        #1 m_done = 1'b0;
        m_SS_n = 1'b1;
      end
    end
  end

  // Monitor: pop expectations when the DUT presents a write or a done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk1("gnt_exclusive", gnt0 & gnt1, 1'b0);
      if (m_wrt) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m_wrt: got m_wrt=1 cmd=%h expected none at %0t", m_cmd, $time);
        end else begin
          e = exp_q.pop_front();
          chk1("event_is_wrt", e.is_done, 1'b0);
          chk16("m_cmd", m_cmd, e.cmd);
          chk1("wrt_owner_gnt", e.port ? gnt1 : gnt0, 1'b1);
        end
      end
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done0=%b done1=%b expected none at %0t", done0, done1, $time);
        end else begin
          e = exp_q.pop_front();
          chk1("event_is_done", e.is_done, 1'b1);
          chk1("done_port", done1, e.port);
          chk1("done_single", done0 & done1, 1'b0);
        end
      end
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    req0  = 1'b0; req1  = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    wrt0  = 1'b0; wrt1  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // One transfer by an already-granted port; returns one edge after done.
  task automatic do_xfer(input bit port, input logic [15:0] c);
    bit found     = 1'b0;
    bit other_bad = 1'b0;
    bit own_low   = 1'b0;
    exp_t ew;
    exp_t ed;
    ew = '{1'b0, port, c};
    ed = '{1'b1, port, c};
    exp_q.push_back(ew);
    exp_q.push_back(ed);
    if (port) begin cmd1 = c; wrt1 = 1'b1; end
    else      begin cmd0 = c; wrt0 = 1'b1; end
    tick();
    wrt0 = 1'b0;
    wrt1 = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((port ? SS0_n : SS1_n) !== 1'b1) other_bad = 1'b1;
      if ((port ? SS1_n : SS0_n) === 1'b0) own_low = 1'b1;
      if (port ? done1 : done0) found = 1'b1;
    end
    chk1("xfer_done_seen", found, 1'b1);
    chk1("ss_other_high", other_bad, 1'b0);
    chk1("ss_owner_low", own_low, 1'b1);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] c;
    cmd0 = 16'h0000;
    cmd1 = 16'h0000;
    do_reset();

    // Reset state
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    chk1("rst_m_wrt", m_wrt, 1'b0);
    chk16("rst_m_cmd", m_cmd, 16'h0000);
    chk1("rst_ss0", SS0_n, 1'b1);
    chk1("rst_ss1", SS1_n, 1'b1);

    // Single requester on port 0
    cmd0 = 16'hA255;
    req0 = 1'b1;
    chk1("t1_gnt0_before", gnt0, 1'b0);
    tick();
    chk1("t1_gnt0", gnt0, 1'b1);
    chk1("t1_gnt1", gnt1, 1'b0);
    do_xfer(1'b0, 16'hA255);
    req0 = 1'b0;
    tick();
    chk1("t1_gnt0_released", gnt0, 1'b0);

    // Simultaneous requests alternate strictly
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk1("t2_first_gnt0", gnt0, 1'b1);
    chk1("t2_first_gnt1", gnt1, 1'b0);
    do_xfer(1'b0, 16'h1111);
    tick();
    chk1("t2_second_gnt1", gnt1, 1'b1);
    chk1("t2_second_gnt0", gnt0, 1'b0);
    do_xfer(1'b1, 16'h2222);
    tick();
    chk1("t2_third_gnt0", gnt0, 1'b1);
    chk1("t2_third_gnt1", gnt1, 1'b0);
    do_xfer(1'b0, 16'h3333);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk1("t2_idle_gnt0", gnt0, 1'b0);
    chk1("t2_idle_gnt1", gnt1, 1'b0);

    // Inertial burst of 4 with port 1 pending
    do_reset();
    req0  = 1'b1;
    lock0 = 1'b1;
    tick();
    req1 = 1'b1;
    chk1("t3_gnt0", gnt0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lock0 = 1'b0;
      c = 16'hA0F0 | 16'(i);
      do_xfer(1'b0, c);
      if (i < 3) begin
        chk1("t3_burst_gnt0", gnt0, 1'b1);
        chk1("t3_burst_gnt1", gnt1, 1'b0);
      end
    end
    chk1("t3_handoff_gnt1_low", gnt1, 1'b0);
    req0 = 1'b0;
    tick();
    chk1("t3_handoff_gnt1", gnt1, 1'b1);
    chk1("t3_handoff_gnt0", gnt0, 1'b0);
    req1 = 1'b0;
    tick();
    chk1("t3_release_gnt1", gnt1, 1'b0);

    // Idle grant timeout on port 1 with port 0 pending
    do_reset();
    req1 = 1'b1;
    tick();
    req0 = 1'b1;
    chk1("t4_gnt1", gnt1, 1'b1);
    repeat (TMO_CYC_DEFAULT - 1) tick();
    chk1("t4_gnt1_last_cycle", gnt1, 1'b1);
    tick();
    chk1("t4_gnt1_revoked", gnt1, 1'b0);
    req1 = 1'b0;
    tick();
    chk1("t4_gnt0_pending", gnt0, 1'b1);
    chk1("t4_gnt1_after", gnt1, 1'b0);

    // Non-owner wrt is dropped
    cmd0 = 16'hBEEF;
    cmd1 = 16'h5A5A;
    wrt1 = 1'b1;
    #1;
    chk1("t5_nonowner_m_wrt", m_wrt, 1'b0);
    chk16("t5_nonowner_m_cmd", m_cmd, 16'hBEEF);
    tick();
    wrt1 = 1'b0;
    chk1("t5_still_gnt0", gnt0, 1'b1);
    chk1("t5_no_gnt1", gnt1, 1'b0);

    // Reset in the middle of a transfer
    begin
      exp_t ew;
      ew = '{1'b0, 1'b0, 16'hBEEF};
      exp_q.push_back(ew);
    end
    wrt0 = 1'b1;
    tick();
    wrt0 = 1'b0;
    tick();
    chk1("t5_busy_ss0_low", SS0_n, 1'b0);
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req0 = 1'b0;
    chk1("t5_rst_gnt0", gnt0, 1'b0);
    chk1("t5_rst_gnt1", gnt1, 1'b0);
    chk1("t5_rst_ss0", SS0_n, 1'b1);
    chk1("t5_rst_ss1", SS1_n, 1'b1);
    chk16("t5_rst_m_cmd", m_cmd, 16'h0000);
    repeat (12) tick();
    chk1("t5_after_ss0", SS0_n, 1'b1);
    chk16("exp_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
